multicycle_control_fsm: RTL

//  Multi-cycle sequencer for the RV32I core datapath (PC, register file, ALU, one unified memory).

---
 rtl/multicycle_control_fsm.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: steps each instruction through FETCH..WB,
// drives datapath enables, handles the memory handshake, traps and retire counting.
module multicycle_control_fsm #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             memReady,
  output logic             memReq,
  output logic             memWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regWrite,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       resultSrc,
  output logic [3:0]       aluControl,
  output logic [1:0]       trapCause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_trap_cause;
  logic [CNT_W-1:0]  r_instret;

  logic       w_in_access;
  logic       w_timeout;
  logic       w_retire;
  logic       w_trap_set;
  logic [1:0] w_trap_cause;
  logic       w_f3_legal;
  logic [3:0] w_alu_op;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic [3:0] w_alu_control;

  assign w_in_access = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout   = w_in_access && !memReady && (r_wait == WAIT_LAST);

  // R/I funct3 legality and ALU operation
  always_comb begin
    w_f3_legal = 1'b1;
    w_alu_op   = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_op = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_op = ALU_SLT;
      3'b100:  w_alu_op = ALU_XOR;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_f3_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and Moore outputs; access-state strobes are qualified by memReady
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_trap_set    = 1'b0;
    w_trap_cause  = 2'b00;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_result_src  = 2'b00;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        if (w_timeout) begin
          w_next       = S_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_TIMEOUT;
        end else if (memReady) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        if (((opcode == OP_LW) || (opcode == OP_SW)) && (funct3 == 3'b010)) begin
          w_next = S_MEMADR;
        end else if ((opcode == OP_R) && w_f3_legal) begin
          w_next = S_EXECR;
        end else if ((opcode == OP_I) && w_f3_legal) begin
          w_next = S_EXECI;
        end else if ((opcode == OP_BEQ) && (funct3 == 3'b000)) begin
          w_next = S_BEQ;
        end else if (opcode == OP_JAL) begin
          w_next = S_JAL;
        end else begin
          w_next       = S_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_ILLEGAL;
        end
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (w_timeout) begin
          w_next       = S_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_TIMEOUT;
        end else if (memReady) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (w_timeout) begin
          w_next       = S_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_TIMEOUT;
        end else if (memReady) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECR: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = w_alu_op;
        w_next        = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = w_alu_op;
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = ALU_SUB;
        w_pc_write    = zero;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Bus wait counter: restarts on each new access or completed handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait <= '0;
    end else if ((w_next != r_state) &&
                 ((w_next == S_FETCH) || (w_next == S_MEMREAD) || (w_next == S_MEMWRITE))) begin
      r_wait <= '0;
    end else if (w_in_access && memReady) begin
      r_wait <= '0;
    end else if (w_in_access) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trap_cause <= 2'b00;
    end else if (w_trap_set && (r_trap_cause == 2'b00)) begin
      r_trap_cause <= w_trap_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Side-effecting strobes are suppressed while reset is held
  assign memReq     = w_mem_req   && !reset;
  assign memWrite   = w_mem_write && !reset;
  assign irWrite    = w_ir_write  && !reset;
  assign pcWrite    = w_pc_write  && !reset;
  assign regWrite   = w_reg_write && !reset;
  assign adrSrc     = w_adr_src;
  assign aluSrcA    = w_alu_src_a;
  assign aluSrcB    = w_alu_src_b;
  assign resultSrc  = w_result_src;
  assign aluControl = w_alu_control;
  assign trapCause  = r_trap_cause;
  assign state      = r_state;
  assign instret    = r_instret;

endmodule
